instruction_fetch: RTL and testbench

Instruction fetch stage: owns the program counter, issues requests to the instruction memory over a req/ack handshake, and presents fetched instruction plus PC+4 to the IF/ID pipeline register. Sits directly upstream of IF/ID. Honours a pipeline stall from the hazard unit, which drives the inverse of IF/ID WriteEn. Honours a branch/jump redirect with a flush bubble. Absorbs variable instruction-memory latency with a one-entry hold buffer.

---
 rtl/instruction_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
//
// Instruction fetch stage. Owns the program counter, requests instruction
// words from instruction memory over a req/ack handshake and presents the
// fetched word plus PC+4 to the IF/ID pipeline register.
//
// Handshake: IMemReq is held high with IMemAddr stable until the cycle in
// which IMemAck = 1; that cycle completes the transfer and IMemData is
// sampled at its closing edge. IMemAck seen while IMemReq = 0 is ignored.
// Ack may arrive in the same cycle the request is raised.
//
// Parameters:
//   RESET_PC        PC value loaded on reset (low two bits must be zero).
//
// Ports:
//   Clk             clock, all state updates on posedge
//   Rst_n           asynchronous active-low reset
//   Stall           1 = IF/ID is not accepting, hold outputs
//   Redirect        branch/jump taken this cycle (overrides Stall)
//   RedirectTarget  new PC, bits [1:0] treated as 00
//   IMemReq         fetch request to instruction memory
//   IMemAddr        fetch address (the current PC)
//   IMemAck         IMemData is valid, completes the request
//   IMemData        instruction word from memory
//   InstructionOut  instruction to IF/ID, 0 (NOP) when not valid
//   PCAddOut        PC+4 of the fetched instruction
//   InstrValid      InstructionOut holds a real instruction
//   FetchCount      delivered-instruction counter (FETCH_COUNT_EN only)
//   state_dbg       current FSM state (FETCH=0, HOLD=1, DISCARD=2)
//
// Optional feature: define FETCH_COUNT_EN to add the FetchCount output, a
// free-running 32-bit count of instructions delivered to IF/ID.
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCAddOut,
    output logic        InstrValid,
`ifdef FETCH_COUNT_EN
    output logic [31:0] FetchCount,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        hold_full;
    // Goes high at the first edge after reset release; keeps IMemReq low
    // throughout reset and for the cycle in which reset is released.
    logic        started;

    logic [31:0] instr_q;
    logic [31:0] pcadd_q;
    logic        valid_q;

    logic        ack_ok;
    logic [31:0] pc_plus4;
    logic [31:0] target_al;

    // Request is up in FETCH and DISCARD; HOLD parks the fetch unit.
    assign IMemReq   = started && (state != S_HOLD);
    assign IMemAddr  = pc;
    // An ack only counts while a request is actually being presented.
    assign ack_ok    = IMemAck && IMemReq;
    assign pc_plus4  = pc + 32'd4;
    assign target_al = RedirectTarget & ~32'h0000_0003;

    assign InstructionOut = instr_q;
    assign PCAddOut       = pcadd_q;
    assign InstrValid     = valid_q;
    assign state_dbg      = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            pending_pc <= RESET_PC;
            hold_instr <= 32'h0000_0000;
            hold_pc4   <= 32'h0000_0000;
            hold_full  <= 1'b0;
            started    <= 1'b0;
            instr_q    <= 32'h0000_0000;
            pcadd_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (Redirect) begin
                // Redirect wins over Stall: bubble out, buffered word dropped.
                valid_q   <= 1'b0;
                instr_q   <= 32'h0000_0000;
                hold_full <= 1'b0;
                case (state)
                    S_FETCH: begin
                        if (ack_ok || !IMemReq) begin
                            // Nothing left outstanding; acked data is dropped.
                            pc    <= target_al;
                            state <= S_FETCH;
                        end else begin
                            // Request in flight must complete at its old
                            // address before the target can be fetched.
                            pending_pc <= target_al;
                            state      <= S_DISCARD;
                        end
                    end
                    S_HOLD: begin
                        pc    <= target_al;
                        state <= S_FETCH;
                    end
                    S_DISCARD: begin
                        if (ack_ok) begin
                            pc    <= target_al;
                            state <= S_FETCH;
                        end else begin
                            pending_pc <= target_al;
                        end
                    end
                    default: begin
                        pc    <= target_al;
                        state <= S_FETCH;
                    end
                endcase
            end else begin
                case (state)
                    S_FETCH: begin
                        if (ack_ok) begin
                            pc <= pc_plus4;
                            if (Stall) begin
                                // IF/ID busy: park the word until it frees up.
                                hold_instr <= IMemData;
                                hold_pc4   <= pc_plus4;
                                hold_full  <= 1'b1;
                                state      <= S_HOLD;
                            end else begin
                                instr_q <= IMemData;
                                pcadd_q <= pc_plus4;
                                valid_q <= 1'b1;
                            end
                        end else if (!Stall) begin
                            // Memory still busy: feed IF/ID a bubble.
                            valid_q <= 1'b0;
                            instr_q <= 32'h0000_0000;
                        end
                    end
                    S_HOLD: begin
                        if (!Stall) begin
                            instr_q   <= hold_full ? hold_instr : 32'h0000_0000;
                            pcadd_q   <= hold_pc4;
                            valid_q   <= hold_full;
                            hold_full <= 1'b0;
                            state     <= S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        // Outputs already hold the redirect bubble.
                        if (ack_ok) begin
                            pc    <= pending_pc;
                            state <= S_FETCH;
                        end
                    end
                    default: begin
                        state <= S_FETCH;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic        deliver;
    logic [31:0] fetch_count_q;

    // Same conditions under which the FSM loads a real instruction into
    // the output register.
    assign deliver = !Redirect && !Stall &&
                     (((state == S_FETCH) && ack_ok) ||
                      ((state == S_HOLD) && hold_full));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_count_q <= 32'h0000_0000;
        end else if (deliver) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign FetchCount = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch
//
// Testbench for instruction_fetch. A memory responder with programmable
// latency answers every request with 0x1000_0000 + address. The reference
// model tracks only the architectural instruction stream: the address of the
// next instruction IF/ID should receive, which advances by 4 per delivery and
// jumps to the aligned target on every redirect. Rules checked each cycle:
// stall holds outputs, redirect yields a bubble, a delivery carries the
// expected word and PC+4, and a pending request keeps its address.
// A second instance with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// ============================================================================
module tb_instruction_fetch;

    logic        Clk;
    logic        Rst_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] InstructionOut;
    logic [31:0] PCAddOut;
    logic        InstrValid;
    logic [1:0]  state_dbg;
`ifdef FETCH_COUNT_EN
    logic [31:0] FetchCount;
    logic [31:0] w_count;
    logic [31:0] exp_cnt;
`endif

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_data;
    logic [31:0] w_instr;
    logic [31:0] w_pcadd;
    logic        w_valid;
    logic [1:0]  w_state;

    int          checks;
    int          errors;

    // Reference model / memory responder state
    logic [31:0] exp_pc;
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          wait_cnt;
    int          lat_min;
    int          lat_max;

    instruction_fetch dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemAck        (IMemAck),
        .IMemData       (IMemData),
        .InstructionOut (InstructionOut),
        .PCAddOut       (PCAddOut),
        .InstrValid     (InstrValid),
`ifdef FETCH_COUNT_EN
        .FetchCount     (FetchCount),
`endif
        .state_dbg      (state_dbg)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .IMemReq        (w_req),
        .IMemAddr       (w_addr),
        .IMemAck        (w_ack),
        .IMemData       (w_data),
        .InstructionOut (w_instr),
        .PCAddOut       (w_pcadd),
        .InstrValid     (w_valid),
`ifdef FETCH_COUNT_EN
        .FetchCount     (w_count),
`endif
        .state_dbg      (w_state)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic model_reset();
        exp_pc     = 32'h0000_0000;
        pend_valid = 1'b0;
        pend_addr  = 32'h0000_0000;
        wait_cnt   = $urandom_range(lat_min, lat_max);
`ifdef FETCH_COUNT_EN
        exp_cnt    = 32'h0;
`endif
    endtask

    // ---------------- driver + scoreboard, one clock per call ----------------
    // Entered and left at a negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        logic        req_s;
        logic [31:0] addr_s;
        logic        ack_s;
        logic [31:0] p_instr;
        logic [31:0] p_pcadd;
        logic        p_valid;
        req_s  = IMemReq;
        addr_s = IMemAddr;
        if (pend_valid) begin
            checks++;
            if (req_s !== 1'b1 || addr_s !== pend_addr) begin
                errors++;
                $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h",
                         req_s, addr_s, pend_addr);
            end
        end
        Stall          = s;
        Redirect       = r;
        RedirectTarget = t;
        ack_s          = 1'b0;
        if (req_s) begin
            if (wait_cnt == 0) begin
                IMemAck  = 1'b1;
                IMemData = mem_word(addr_s);
                ack_s    = 1'b1;
            end else begin
                IMemAck  = 1'b0;
                IMemData = $urandom;
                wait_cnt = wait_cnt - 1;
            end
        end else begin
            // Stray acks without a request must be ignored.
            IMemAck  = ($urandom_range(0, 1) == 1);
            IMemData = 32'hDEAD_BEEF;
        end
        p_instr = InstructionOut;
        p_pcadd = PCAddOut;
        p_valid = InstrValid;

        @(posedge Clk);
        #1;
        pend_valid = req_s && !ack_s;
        pend_addr  = addr_s;
        if (ack_s) wait_cnt = $urandom_range(lat_min, lat_max);

        if (r) begin
            exp_pc = t & ~32'h3;
            checks++;
            if (InstrValid !== 1'b0 || InstructionOut !== 32'h0) begin
                errors++;
                $display("FAIL redirect_bubble: valid=%0b instr=%h, required valid=0 instr=0",
                         InstrValid, InstructionOut);
            end
        end else if (s) begin
            checks++;
            if (InstrValid !== p_valid || InstructionOut !== p_instr || PCAddOut !== p_pcadd) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b instr=%h pcadd=%h, required %0b %h %h",
                         InstrValid, InstructionOut, PCAddOut, p_valid, p_instr, p_pcadd);
            end
        end else if (InstrValid === 1'b1) begin
            checks++;
            if (InstructionOut !== mem_word(exp_pc) || PCAddOut !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL delivery: instr=%h pcadd=%h, required instr=%h pcadd=%h",
                         InstructionOut, PCAddOut, mem_word(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
`ifdef FETCH_COUNT_EN
            exp_cnt = exp_cnt + 32'd1;
`endif
        end else begin
            checks++;
            if (InstrValid !== 1'b0 || InstructionOut !== 32'h0) begin
                errors++;
                $display("FAIL bubble: valid=%0b instr=%h, required valid=0 instr=0",
                         InstrValid, InstructionOut);
            end
        end
`ifdef FETCH_COUNT_EN
        checks++;
        if (FetchCount !== exp_cnt) begin
            errors++;
            $display("FAIL fetch_count: got %0d, required %0d", FetchCount, exp_cnt);
        end
`endif
        @(negedge Clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        RedirectTarget = 32'h0;
        IMemAck = 1'b0;
        IMemData = 32'h0;
        w_ack = 1'b0;
        w_data = 32'h0;
        lat_min = 0;
        lat_max = 0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (InstructionOut !== 32'h0 || PCAddOut !== 32'h0 || InstrValid !== 1'b0 || IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: instr=%h pcadd=%h valid=%0b req=%0b, required all 0",
                     InstructionOut, PCAddOut, InstrValid, IMemReq);
        end
        Rst_n = 1'b1;
        checks++;
        if (IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL req_at_release: req=%0b, required 0", IMemReq);
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%0b addr=%h, required req=1 addr=0", IMemReq, IMemAddr);
        end
    endtask

    task automatic test_zero_wait();
        lat_min = 0;
        lat_max = 0;
        wait_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (IMemAddr !== 32'(i * 4)) begin
                errors++;
                $display("FAIL zw_addr: addr=%h, required %h", IMemAddr, 32'(i * 4));
            end
            step(1'b0, 1'b0, 32'h0);
            checks++;
            if (InstrValid !== 1'b1 || InstructionOut !== 32'h1000_0000 + 32'(i * 4) ||
                PCAddOut !== 32'((i + 1) * 4)) begin
                errors++;
                $display("FAIL zw_out: valid=%0b instr=%h pcadd=%h, required 1 %h %h",
                         InstrValid, InstructionOut, PCAddOut,
                         32'h1000_0000 + 32'(i * 4), 32'((i + 1) * 4));
            end
        end
    endtask

    task automatic test_wait3();
        lat_min = 3;
        lat_max = 3;
        wait_cnt = 3;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b0, 32'h0);
                checks++;
                if (InstrValid !== (k == 3)) begin
                    errors++;
                    $display("FAIL wait3_valid: cycle %0d valid=%0b, required %0b",
                             k, InstrValid, (k == 3));
                end
            end
        end
        lat_min = 0;
        lat_max = 0;
    endtask

    task automatic test_stall_hold();
        logic [31:0] first_addr;
        lat_min = 0;
        lat_max = 0;
        wait_cnt = 0;
        first_addr = exp_pc;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h0);
            checks++;
            if (IMemReq !== 1'b0) begin
                errors++;
                $display("FAIL hold_req: cycle %0d req=%0b, required 0", k, IMemReq);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (InstrValid !== 1'b1 || PCAddOut !== first_addr + 32'd4 || IMemReq !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%0b pcadd=%h req=%0b, required 1 %h 1",
                     InstrValid, PCAddOut, IMemReq, first_addr + 32'd4);
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (PCAddOut !== first_addr + 32'd8) begin
            errors++;
            $display("FAIL hold_next: pcadd=%h, required %h", PCAddOut, first_addr + 32'd8);
        end
    endtask

    task automatic test_redirect_discard();
        logic [31:0] old_addr;
        logic        seen;
        lat_min = 3;
        lat_max = 3;
        wait_cnt = 3;
        step(1'b0, 1'b0, 32'h0);
        old_addr = IMemAddr;
        step(1'b0, 1'b1, 32'h0000_0200);
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== old_addr || state_dbg === 2'd0) begin
            errors++;
            $display("FAIL discard_enter: req=%0b addr=%h state=%0d, required req=1 addr=%h non-FETCH",
                     IMemReq, IMemAddr, state_dbg, old_addr);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (IMemAddr !== 32'h0000_0200 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL discard_exit: addr=%h valid=%0b, required addr=200 valid=0",
                     IMemAddr, InstrValid);
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step(1'b0, 1'b0, 32'h0);
            if (InstrValid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (PCAddOut !== 32'h0000_0204 || InstructionOut !== 32'h1000_0200) begin
                    errors++;
                    $display("FAIL discard_target: pcadd=%h instr=%h, required 204 10000200",
                             PCAddOut, InstructionOut);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL discard_timeout: target word never delivered");
        end
        lat_min = 0;
        lat_max = 0;
    endtask

    task automatic test_redirect_combo();
        lat_min = 0;
        lat_max = 0;
        wait_cnt = 0;
        step(1'b1, 1'b1, 32'h0000_0300);
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h0000_0300 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_stall: req=%0b addr=%h valid=%0b, required 1 300 0",
                     IMemReq, IMemAddr, InstrValid);
        end
        step(1'b0, 1'b1, 32'h0000_0203);
        checks++;
        if (IMemAddr !== 32'h0000_0200 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack: addr=%h valid=%0b, required 200 0", IMemAddr, InstrValid);
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (PCAddOut !== 32'h0000_0204 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL redir_resume: pcadd=%h valid=%0b, required 204 1", PCAddOut, InstrValid);
        end
        // Park a word in HOLD, then redirect away from it.
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0400);
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h0000_0400 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_hold: req=%0b addr=%h valid=%0b, required 1 400 0",
                     IMemReq, IMemAddr, InstrValid);
        end
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (PCAddOut !== 32'h0000_0404) begin
            errors++;
            $display("FAIL redir_hold_next: pcadd=%h, required 404", PCAddOut);
        end
    endtask

    task automatic test_random();
        logic        s;
        logic        r;
        logic [31:0] t;
        lat_min = 0;
        lat_max = 3;
        for (int k = 0; k < 400; k++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 19) == 0);
            t = $urandom;
            step(s, r, t);
        end
        lat_min = 0;
        lat_max = 0;
    endtask

    task automatic test_reset_mid();
        lat_min = 0;
        lat_max = 0;
        wait_cnt = 0;
        step(1'b0, 1'b0, 32'h0);
        wait_cnt = 5;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (InstructionOut !== 32'h0 || PCAddOut !== 32'h0 || InstrValid !== 1'b0 || IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: instr=%h pcadd=%h valid=%0b req=%0b, required all 0",
                     InstructionOut, PCAddOut, InstrValid, IMemReq);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        wait_cnt = 0;
        step(1'b0, 1'b0, 32'h0);
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
            errors++;
            $display("FAIL restart_addr: req=%0b addr=%h, required 1 0", IMemReq, IMemAddr);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        Stall = 1'b0;
        Redirect = 1'b0;
        IMemAck = 1'b0;
        w_ack = 1'b0;
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first_req: req=%0b addr=%h, required 1 fffffffc", w_req, w_addr);
        end
        w_ack = 1'b1;
        w_data = mem_word(w_addr);
        @(posedge Clk);
        #1;
        checks++;
        if (w_valid !== 1'b1 || w_instr !== 32'h0FFF_FFFC || w_pcadd !== 32'h0 || w_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out: valid=%0b instr=%h pcadd=%h addr=%h, required 1 0ffffffc 0 0",
                     w_valid, w_instr, w_pcadd, w_addr);
        end
        w_ack = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall_hold();
        test_redirect_discard();
        test_redirect_combo();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
